// File: rtl/dallanma_paketi.sv
// Shared types and constants for the branch resolution unit.
package dallanma_paketi;

  localparam int unsigned PS_W    = 32;
  localparam int unsigned HEDEF_W = 32;

  localparam logic [PS_W-1:0] PS_ARTIM = 32'd4;

  // FSM state encodings
  localparam logic [0:0] COZ   = 1'b0;
  localparam logic [0:0] BEKLE = 1'b1;

  // One in-flight prediction
  typedef struct packed {
    logic [PS_W-1:0]    ps;
    logic               atladi;
    logic [HEDEF_W-1:0] hedef;
  } ongoru_girdisi_t;

endpackage

// File: rtl/dallanma_cozucu_if.sv
// Fetch/execute side bus of dallanma_cozucu; master = pipeline, slave = resolver.
interface dallanma_cozucu_if;
  logic        ongoru_kaydet_i;
  logic [31:0] ongoru_ps_i;
  logic        ongoru_atladi_i;
  logic [31:0] ongoru_hedef_i;
  logic        cozum_gecerli_i;
  logic [31:0] cozum_ps_i;
  logic        cozum_atladi_i;
  logic [31:0] cozum_hedef_i;
  logic        temizle_i;
  logic        guncelle_gecerli_o;
  logic        guncelle_atladi_o;
  logic [31:0] guncelle_ps_o;
  logic [31:0] guncelle_hedef_adresi_o;
  logic        dallanma_hata_o;
  logic [31:0] duzeltilmis_ps_o;
  logic        kuyruk_dolu_o;

  modport master (
    output ongoru_kaydet_i, ongoru_ps_i, ongoru_atladi_i, ongoru_hedef_i,
    output cozum_gecerli_i, cozum_ps_i, cozum_atladi_i, cozum_hedef_i, temizle_i,
    input  guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o, guncelle_hedef_adresi_o,
    input  dallanma_hata_o, duzeltilmis_ps_o, kuyruk_dolu_o
  );

  modport slave (
    input  ongoru_kaydet_i, ongoru_ps_i, ongoru_atladi_i, ongoru_hedef_i,
    input  cozum_gecerli_i, cozum_ps_i, cozum_atladi_i, cozum_hedef_i, temizle_i,
    output guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o, guncelle_hedef_adresi_o,
    output dallanma_hata_o, duzeltilmis_ps_o, kuyruk_dolu_o
  );
endinterface

// File: rtl/ongoru_kuyrugu.sv
// Synchronous FIFO of in-flight predictions; clear has priority, payload not reset.
module ongoru_kuyrugu
  import dallanma_paketi::*;
#(
  parameter int unsigned DERINLIK = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  ongoru_girdisi_t veri_i,
  output ongoru_girdisi_t bas_o,
  output logic            dolu_o,
  output logic            bos_o
);

  localparam int unsigned PTR_W = $clog2(DERINLIK);
  localparam int unsigned CNT_W = PTR_W + 1;

  ongoru_girdisi_t   mem_q [DERINLIK];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign dolu_o = (count_q == CNT_W'(DERINLIK));
  assign bos_o  = (count_q == '0);
  assign bas_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    push_ok  = push_i && !dolu_o;
    pop_ok   = pop_i && !bos_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage, deliberately without reset
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= veri_i;
  end

endmodule

// File: rtl/dallanma_cozucu.sv
// Branch resolution unit: queues predictions, compares with execute outcome,
// issues predictor updates and misprediction redirects.
// Optional macro DALLANMA_SAYAC_EN adds saturating resolve/mispredict counters.
module dallanma_cozucu
  import dallanma_paketi::*;
#(
  parameter int unsigned KUYRUK_DERINLIGI = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dallanma_cozucu_if.slave    bus
`ifdef DALLANMA_SAYAC_EN
  ,
  output logic [31:0]         cozulen_sayisi_o,
  output logic [31:0]         hatali_sayisi_o
`endif
);

  logic [0:0]      state_q, state_d;
  logic            upd_q, upd_d;
  logic            upd_atladi_q, upd_atladi_d;
  logic [31:0]     upd_ps_q, upd_ps_d;
  logic [31:0]     upd_hedef_q, upd_hedef_d;
  logic            hata_q, hata_d;
  logic [31:0]     duz_ps_q, duz_ps_d;

  logic            cozum_c, hata_c, temiz_c, push_c, pop_c;
  logic            bas_atladi_c;
  logic            dolu, bos;
  ongoru_girdisi_t giris, bas;

  assign giris = '{ps: bus.ongoru_ps_i, atladi: bus.ongoru_atladi_i, hedef: bus.ongoru_hedef_i};

  ongoru_kuyrugu #(.DERINLIK(KUYRUK_DERINLIGI)) u_kuyruk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .clear_i (temiz_c),
    .veri_i  (giris),
    .bas_o   (bas),
    .dolu_o  (dolu),
    .bos_o   (bos)
  );

  // Resolve compare, queue control, FSM next-state and registered outputs
  always_comb begin
    cozum_c      = bus.cozum_gecerli_i && !bus.temizle_i;
    bas_atladi_c = bos ? 1'b0 : bas.atladi;
    hata_c       = cozum_c &&
                   ((bas_atladi_c != bus.cozum_atladi_i) ||
                    (bas_atladi_c && bus.cozum_atladi_i && (bas.hedef != bus.cozum_hedef_i)) ||
                    (!bos && (bas.ps != bus.cozum_ps_i)));
    temiz_c      = bus.temizle_i || hata_c;
    push_c       = bus.ongoru_kaydet_i && (state_q == COZ) && !temiz_c && !dolu;
    pop_c        = cozum_c && !hata_c;

    state_d      = state_q;
    upd_d        = 1'b0;
    upd_atladi_d = 1'b0;
    upd_ps_d     = '0;
    upd_hedef_d  = '0;
    hata_d       = 1'b0;
    duz_ps_d     = '0;

    case (state_q)
      COZ:     if (temiz_c) state_d = BEKLE;
      default: state_d = COZ;
    endcase

    if (cozum_c) begin
      upd_d        = 1'b1;
      upd_atladi_d = bus.cozum_atladi_i;
      upd_ps_d     = bus.cozum_ps_i;
      upd_hedef_d  = bus.cozum_hedef_i;
    end
    if (hata_c) begin
      hata_d   = 1'b1;
      duz_ps_d = bus.cozum_atladi_i ? bus.cozum_hedef_i : bus.cozum_ps_i + PS_ARTIM;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= COZ;
      upd_q        <= 1'b0;
      upd_atladi_q <= 1'b0;
      upd_ps_q     <= '0;
      upd_hedef_q  <= '0;
      hata_q       <= 1'b0;
      duz_ps_q     <= '0;
    end else begin
      state_q      <= state_d;
      upd_q        <= upd_d;
      upd_atladi_q <= upd_atladi_d;
      upd_ps_q     <= upd_ps_d;
      upd_hedef_q  <= upd_hedef_d;
      hata_q       <= hata_d;
      duz_ps_q     <= duz_ps_d;
    end
  end

  assign bus.guncelle_gecerli_o      = upd_q;
  assign bus.guncelle_atladi_o       = upd_atladi_q;
  assign bus.guncelle_ps_o           = upd_ps_q;
  assign bus.guncelle_hedef_adresi_o = upd_hedef_q;
  assign bus.dallanma_hata_o         = hata_q;
  assign bus.duzeltilmis_ps_o        = duz_ps_q;
  assign bus.kuyruk_dolu_o           = dolu;

`ifdef DALLANMA_SAYAC_EN
  logic [31:0] cozulen_q, cozulen_d;
  logic [31:0] hatali_q, hatali_d;

  // Saturating statistics counters
  always_comb begin
    cozulen_d = cozulen_q;
    hatali_d  = hatali_q;
    if (cozum_c && (cozulen_q != '1)) cozulen_d = cozulen_q + 32'd1;
    if (hata_c && (hatali_q != '1))   hatali_d  = hatali_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cozulen_q <= '0;
      hatali_q  <= '0;
    end else begin
      cozulen_q <= cozulen_d;
      hatali_q  <= hatali_d;
    end
  end

  assign cozulen_sayisi_o = cozulen_q;
  assign hatali_sayisi_o  = hatali_q;
`endif

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Self-checking bench for dallanma_cozucu: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_dallanma_cozucu;

  localparam int unsigned D = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  dallanma_cozucu_if bus ();

`ifdef DALLANMA_SAYAC_EN
  logic [31:0] cozulen_sayisi_o, hatali_sayisi_o;
`endif

  dallanma_cozucu #(.KUYRUK_DERINLIGI(D)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef DALLANMA_SAYAC_EN
    ,
    .cozulen_sayisi_o (cozulen_sayisi_o),
    .hatali_sayisi_o  (hatali_sayisi_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] ps;
    logic        atl;
    logic [31:0] h;
  } ent_t;

  ent_t        mq[$];
  bit          bekle;
  logic        e_upd, e_atl, e_hata;
  logic [31:0] e_ps, e_h, e_duz;
  logic [31:0] e_coz, e_hat;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic rst, input logic kay, input logic [31:0] ops,
                      input logic oatl, input logic [31:0] oh, input logic cg,
                      input logic [31:0] cps, input logic catl, input logic [31:0] ch,
                      input logic tem);
    bit   res, mis, do_push;
    ent_t e;
    rst_i = rst;
    bus.ongoru_kaydet_i = kay;  bus.ongoru_ps_i = ops;
    bus.ongoru_atladi_i = oatl; bus.ongoru_hedef_i = oh;
    bus.cozum_gecerli_i = cg;   bus.cozum_ps_i = cps;
    bus.cozum_atladi_i = catl;  bus.cozum_hedef_i = ch;
    bus.temizle_i = tem;

    if (rst) begin
      mq.delete(); bekle = 0;
      e_upd = 0; e_atl = 0; e_ps = 0; e_h = 0; e_hata = 0; e_duz = 0;
      e_coz = 0; e_hat = 0;
    end else begin
      res = cg && !tem;
      mis = 0;
      if (res) begin
        if (mq.size() == 0) mis = catl;
        else mis = (mq[0].atl != catl) || (catl && mq[0].h != ch) || (mq[0].ps != cps);
      end
      e_upd  = res;
      e_atl  = res ? catl : 1'b0;
      e_ps   = res ? cps : 32'd0;
      e_h    = res ? ch : 32'd0;
      e_hata = mis;
      e_duz  = mis ? (catl ? ch : cps + 32'd4) : 32'd0;
      do_push = kay && !bekle && !tem && !mis && (mq.size() < D);
      if (tem || mis) mq.delete();
      else begin
        if (res && mq.size() > 0) void'(mq.pop_front());
        if (do_push) begin
          e.ps = ops; e.atl = oatl; e.h = oh;
          mq.push_back(e);
        end
      end
      bekle = !bekle && (tem || mis);
      if (res && e_coz != 32'hFFFF_FFFF) e_coz++;
      if (mis && e_hat != 32'hFFFF_FFFF) e_hat++;
    end

    @(negedge clk_i);
    check("upd_valid", bus.guncelle_gecerli_o, e_upd);
    check("upd_atl", bus.guncelle_atladi_o, e_atl);
    check("upd_ps", bus.guncelle_ps_o, e_ps);
    check("upd_hedef", bus.guncelle_hedef_adresi_o, e_h);
    check("hata", bus.dallanma_hata_o, e_hata);
    check("duz_ps", bus.duzeltilmis_ps_o, e_duz);
    check("dolu", bus.kuyruk_dolu_o, (mq.size() == D) ? 32'd1 : 32'd0);
`ifdef DALLANMA_SAYAC_EN
    check("cozulen", cozulen_sayisi_o, e_coz);
    check("hatali", hatali_sayisi_o, e_hat);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] ps, input logic atl, input logic [31:0] h);
    step(0, 1, ps, atl, h, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] ps, input logic atl, input logic [31:0] h);
    step(0, 0, 0, 0, 0, 1, ps, atl, h, 0);
  endtask

  initial begin
    logic        r_rst, r_kay, r_oatl, r_cg, r_catl, r_tem;
    logic [31:0] r_ops, r_oh, r_cps, r_ch;

    rst_i = 1'b1;
    bus.ongoru_kaydet_i = 0; bus.ongoru_ps_i = 0; bus.ongoru_atladi_i = 0;
    bus.ongoru_hedef_i = 0; bus.cozum_gecerli_i = 0; bus.cozum_ps_i = 0;
    bus.cozum_atladi_i = 0; bus.cozum_hedef_i = 0; bus.temizle_i = 0;
    @(negedge clk_i);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h10, 1, 32'h20, 1, 32'h10, 1, 32'h20, 0);
    check("rst_upd", bus.guncelle_gecerli_o, 0);
    check("rst_dolu", bus.kuyruk_dolu_o, 0);

    // Scenario 1: correct taken prediction
    push(32'h100, 1, 32'h200);
    resolve(32'h100, 1, 32'h200);
    check("s1_upd", bus.guncelle_gecerli_o, 1);
    check("s1_hata", bus.dallanma_hata_o, 0);
    idle();

    // Scenario 2: not-taken predicted, taken actual; push in BEKLE ignored
    push(32'h104, 0, 32'h0);
    resolve(32'h104, 1, 32'h300);
    check("s2_hata", bus.dallanma_hata_o, 1);
    check("s2_duz", bus.duzeltilmis_ps_o, 32'h300);
    push(32'h500, 1, 32'h600);
    resolve(32'h500, 1, 32'h600);
    check("s2_bekle_drop", bus.dallanma_hata_o, 1);
    idle();

    // Scenario 3: taken predicted, not-taken actual
    push(32'h108, 1, 32'h400);
    resolve(32'h108, 0, 32'h0);
    check("s3_hata", bus.dallanma_hata_o, 1);
    check("s3_duz", bus.duzeltilmis_ps_o, 32'h10C);
    idle();

    // Scenario 4: fill, overflow drop, one resolve clears full
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i) * 4, 0, 0);
    check("s4_full", bus.kuyruk_dolu_o, 1);
    push(32'h300, 1, 32'h999);
    resolve(32'h200, 0, 0);
    check("s4_notfull", bus.kuyruk_dolu_o, 0);
    for (int i = 1; i < 4; i++) resolve(32'h200 + 32'(i) * 4, 0, 0);
    resolve(32'h300, 1, 32'h999);
    check("s4_fifth_dropped", bus.dallanma_hata_o, 1);
    idle();

    // Scenario 5: flush together with resolve
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(i) * 4, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h700, 0, 0, 1);
    check("s5_upd", bus.guncelle_gecerli_o, 0);
    check("s5_hata", bus.dallanma_hata_o, 0);
    idle();
    resolve(32'h700, 0, 0);
    check("s5_empty", bus.dallanma_hata_o, 0);
    idle();

    // Scenario 6: empty-queue resolve at the top of the address space
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resolve(32'hFFFF_FFFC, 0, 0);
    check("s6_hata", bus.dallanma_hata_o, 0);
    check("s6_ps", bus.guncelle_ps_o, 32'hFFFF_FFFC);
    check("s6_duz", bus.duzeltilmis_ps_o, 0);
`ifdef DALLANMA_SAYAC_EN
    check("s6_cnt", cozulen_sayisi_o, 1);
`endif
    idle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_tem  = ($urandom_range(0, 19) == 0);
      r_kay  = ($urandom_range(0, 1) == 1);
      r_ops  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      r_oatl = 1'($urandom_range(0, 1));
      r_oh   = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
      r_cg   = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        r_cps = mq[0].ps; r_catl = mq[0].atl; r_ch = mq[0].h;
        if ($urandom_range(0, 5) == 0) r_ch = r_ch ^ 32'h4;
      end else begin
        r_cps  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        r_catl = 1'($urandom_range(0, 1));
        r_ch   = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
      end
      step(r_rst, r_kay, r_ops, r_oatl, r_oh, r_cg, r_cps, r_catl, r_ch, r_tem);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dallanma_cozucu.md
DALLANMA_COZUCU -- requirements
Module: dallanma_cozucu

Interface
REQ-001 Parameter: KUYRUK_DERINLIGI, 4, depth of the in-flight prediction queue, power of two, 2..16.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 ongoru_kaydet_i  in  1  fetch issued a prediction this cycle; push it.
REQ-005 ongoru_ps_i  in  32  program counter of the predicted branch.
REQ-006 ongoru_atladi_i  in  1  predictor output was taken.
REQ-007 ongoru_hedef_i  in  32  predicted target; meaningful only when ongoru_atladi_i=1.
REQ-008 cozum_gecerli_i  in  1  execute resolved the oldest in-flight branch this cycle.
REQ-009 cozum_ps_i  in  32  program counter of the resolved branch.
REQ-010 cozum_atladi_i  in  1  actual outcome was taken.
REQ-011 cozum_hedef_i  in  32  actual target.
REQ-012 temizle_i  in  1  external pipeline flush, for example an exception.
REQ-013 guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o[31:0], guncelle_hedef_adresi_o[31:0]  out  predictor update port.
REQ-014 dallanma_hata_o  out  1  misprediction pulse.
REQ-015 duzeltilmis_ps_o  out  32  redirect program counter, valid with dallanma_hata_o.
REQ-016 kuyruk_dolu_o  out  1  queue full; fetch shall stall.

Function
REQ-017 All outputs are registered, with 1-cycle latency from cozum_gecerli_i.
REQ-018 Push: when ongoru_kaydet_i=1, the block stores {ps, atladi, hedef}, provided that the queue is not full, the state is COZ, and there is no flush this cycle.
REQ-019 A push while the queue is full is dropped; kuyruk_dolu_o is combinational from occupancy.
REQ-020 Resolve: when cozum_gecerli_i=1, the head entry is popped and compared with the actual outcome.
REQ-021 Resolving against an empty queue is treated as a predicted not-taken branch with target 0.
REQ-022 A misprediction is any of: head atladi differs from cozum_atladi_i; both taken but hedef differs from cozum_hedef_i; head ps differs from cozum_ps_i.
REQ-023 Every resolve produces a 1-cycle pulse on guncelle_gecerli_o, with guncelle_atladi_o=cozum_atladi_i, guncelle_ps_o=cozum_ps_i and guncelle_hedef_adresi_o=cozum_hedef_i.
REQ-024 On a misprediction, dallanma_hata_o=1 for one cycle.
REQ-025 The redirect address is duzeltilmis_ps_o = cozum_atladi_i ? cozum_hedef_i : cozum_ps_i+4, with 32-bit wrap-around.
REQ-026 A misprediction empties the entire queue, because all younger entries are wrong-path.
REQ-027 A push in the same cycle as a misprediction is dropped.
REQ-028 The FSM has two states:
- COZ (normal).
- BEKLE (one cycle after a misprediction or temizle_i, during which pushes are ignored).
REQ-029 The transitions are COZ->BEKLE on a misprediction or temizle_i, and BEKLE->COZ unconditionally.
REQ-030 temizle_i empties the queue and suppresses any same-cycle resolve, so no update and no hata are produced.
REQ-031 A simultaneous push and a correct resolve keep occupancy unchanged; the pointers wrap modulo KUYRUK_DERINLIGI.
REQ-032 An occupancy counter of width clog2(KUYRUK_DERINLIGI)+1 never exceeds KUYRUK_DERINLIGI and never underflows.
REQ-033 Output pulses not driven in a cycle are 0.

Reset
REQ-034 While rst_i=1 at a clock edge, the block sets pointers and occupancy to 0, the state to COZ, and all outputs to 0; kuyruk_dolu_o=0.
REQ-035 Reset mid-operation discards all in-flight entries and emits no update.
REQ-036 Queue payload storage is not reset.

Configuration
REQ-037 The macro DALLANMA_SAYAC_EN, when defined, adds outputs cozulen_sayisi_o[31:0] and hatali_sayisi_o[31:0].
REQ-038 With DALLANMA_SAYAC_EN defined, the counters are saturating, increment per resolve and per misprediction respectively, and are cleared by reset.
REQ-039 Without DALLANMA_SAYAC_EN, the counter ports and logic are absent and behaviour is otherwise identical.

Structure
REQ-040 The shared package dallanma_paketi holds the FSM state encodings (COZ, BEKLE), the entry field widths, and the constant PS_ARTIM=4.
REQ-041 The queue is sub-module ongoru_kuyrugu: a synchronous FIFO with push, pop, clear, full, empty and a head read port.

Verification
REQ-042 Scenario 1: push {0x100,taken,0x200}, then resolve {0x100,taken,0x200} -> guncelle_gecerli_o=1 one cycle later, dallanma_hata_o=0.
REQ-043 Scenario 2: push {0x104,not-taken}, then resolve {0x104,taken,0x300} -> dallanma_hata_o=1 and duzeltilmis_ps_o=0x300; occupancy 0; the next-cycle push is ignored (BEKLE).
REQ-044 Scenario 3: push {0x108,taken,0x400}, then resolve {0x108,not-taken} -> hata=1, duzeltilmis_ps_o=0x10C.
REQ-045 Scenario 4: 4 pushes with depth 4 -> kuyruk_dolu_o=1; a fifth push is dropped; one resolve -> kuyruk_dolu_o=0.
REQ-046 Scenario 5: temizle_i together with cozum_gecerli_i while 3 entries are queued -> no update, no hata, queue empty.
REQ-047 Scenario 6: resolve {0xFFFFFFFC,not-taken} on an empty queue -> no hata, guncelle_ps_o=0xFFFFFFFC, no redirect; with DALLANMA_SAYAC_EN, cozulen_sayisi_o increments to 1.
